spin_round_ctrl: RTL and testbench

//  Game-round sequencer for the LED spinner. Owns prescaler speed and wheel stop:
//  a button starts a spin, a second press (or timeout) coasts the wheel down

---
 rtl/spin_round_ctrl_pkg.sv | 33 +++
 rtl/spin_round_ctrl_btn_sync.sv | 41 ++++
 rtl/spin_round_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_spin_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spin_round_ctrl_pkg.sv
// Shared types and constants for the LED spinner round sequencer:
// FSM state encoding, speed/position widths and the guess judge.
package spin_round_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPIN   = 3'd1,
    ST_COAST  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESULT = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam int SPEED_W = 4;
  localparam int POS_W   = 3;
  localparam int NUM_POS = 6;
  localparam int TIMER_W = 24;

  // A hit needs exactly one guess bit set and that bit at a legal wheel position.
  // Positions 6 and 7 never match because the loop only covers 0..NUM_POS-1.
  function automatic logic judge_hit(input logic [NUM_POS-1:0] guess,
                                     input logic [POS_W-1:0]   pos);
    logic onehot;
    logic sel;
    onehot = ($countones(guess) == 1);
    sel    = 1'b0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (pos == POS_W'(i)) sel = guess[i];
    end
    return onehot && sel;
  endfunction

endpackage

// File: rtl/spin_round_ctrl_btn_sync.sv
// Push-button front end: two-flop synchronizer followed by a registered
// rising-edge detector. A held button yields a single one-cycle pulse,
// three clocks after the raw edge.
module spin_round_ctrl_btn_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Next-state of the synchronizer chain and edge detector.
  always_comb begin
    meta_d  = btn_i;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  // Synchronizer and pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/spin_round_ctrl.sv
// Game-round sequencer for the LED spinner. Starts a spin on a button press,
// coasts the wheel down one speed step every COAST_TICKS wheel ticks on a
// second press or timeout, waits for the wheel to settle, judges the guess
// and keeps score across MAX_ROUNDS rounds. Every output is a flop.
module spin_round_ctrl
  import spin_round_ctrl_pkg::*;
#(
  parameter logic [SPEED_W-1:0] START_SPEED   = 4'd12,
  parameter logic [SPEED_W-1:0] MIN_SPEED     = 4'd2,
  parameter int                 COAST_TICKS   = 4,
  parameter int                 SPIN_TIMEOUT  = 64,
  parameter logic [TIMER_W-1:0] RESULT_CYCLES = 24'd6_000_000,
  parameter logic [3:0]         MAX_ROUNDS    = 4'd8,
  parameter int                 SCORE_W       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 btn_i,
  input  logic                 wheel_tick_i,
  input  logic                 wheel_running_i,
  input  logic [POS_W-1:0]     pos_i,
  input  logic [NUM_POS-1:0]   guess_i,
  output logic [SPEED_W-1:0]   speed_o,
  output logic                 stop_o,
  output logic                 round_active_o,
  output logic                 result_valid_o,
  output logic                 hit_o,
  output logic [SCORE_W-1:0]   score_o,
  output logic [SCORE_W-1:0]   rounds_o,
  output logic                 game_over_o
);

  localparam int TCNT_MAX = (SPIN_TIMEOUT > COAST_TICKS) ? SPIN_TIMEOUT : COAST_TICKS;
  localparam int TCNT_W   = $clog2(TCNT_MAX) + 1;

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic                 stop_q, stop_d;
  logic [TCNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 hit_q, hit_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   rounds_q, rounds_d;
  logic                 round_active_q, round_active_d;
  logic                 result_valid_q, result_valid_d;
  logic                 game_over_q, game_over_d;
  logic                 btn_pulse;
  logic                 hit_now;

  spin_round_ctrl_btn_sync u_btn_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_i),
    .pulse_o (btn_pulse)
  );

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v,
                                                 input logic               en);
    if (!en || v == {SCORE_W{1'b1}}) return v;
    return v + SCORE_W'(1);
  endfunction

  assign hit_now = judge_hit(guess_i, pos_i);

  // Round FSM: next state, speed/stop control, counters and registered flags.
  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    stop_d     = stop_q;
    tick_cnt_d = tick_cnt_q;
    timer_d    = timer_q;
    hit_d      = hit_q;
    score_d    = score_q;
    rounds_d   = rounds_q;
    case (state_q)
      ST_IDLE: begin
        speed_d = '0;
        stop_d  = 1'b1;
        if (btn_pulse) begin
          state_d    = ST_SPIN;
          speed_d    = START_SPEED;
          stop_d     = 1'b0;
          tick_cnt_d = '0;
        end
      end
      ST_SPIN: begin
        if (btn_pulse) begin
          state_d    = ST_COAST;
          tick_cnt_d = '0;
        end else if (wheel_tick_i) begin
          if (tick_cnt_q == TCNT_W'(SPIN_TIMEOUT - 1)) begin
            state_d    = ST_COAST;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end
      ST_COAST: begin
        if (wheel_tick_i) begin
          if (tick_cnt_q == TCNT_W'(COAST_TICKS - 1)) begin
            tick_cnt_d = '0;
            if (speed_q == MIN_SPEED) begin
              stop_d  = 1'b1;
              state_d = ST_SETTLE;
            end else begin
              speed_d = speed_q - SPEED_W'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TCNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!wheel_running_i) begin
          state_d  = ST_RESULT;
          hit_d    = hit_now;
          score_d  = sat_inc(score_q, hit_now);
          rounds_d = rounds_q + SCORE_W'(1);
          speed_d  = '0;
          timer_d  = '0;
        end
      end
      ST_RESULT: begin
        if (timer_q == RESULT_CYCLES - TIMER_W'(1)) begin
          timer_d = '0;
          state_d = (rounds_q == SCORE_W'(MAX_ROUNDS)) ? ST_OVER : ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_OVER: begin
        speed_d = '0;
        stop_d  = 1'b1;
        if (btn_pulse) begin
          score_d  = '0;
          rounds_d = '0;
          hit_d    = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        speed_d = '0;
        stop_d  = 1'b1;
      end
    endcase
    round_active_d = (state_d == ST_SPIN) || (state_d == ST_COAST) || (state_d == ST_SETTLE);
    result_valid_d = (state_d == ST_RESULT);
    game_over_d    = (state_d == ST_OVER);
  end

  // State, datapath counters and output flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      speed_q        <= '0;
      stop_q         <= 1'b1;
      tick_cnt_q     <= '0;
      timer_q        <= '0;
      hit_q          <= 1'b0;
      score_q        <= '0;
      rounds_q       <= '0;
      round_active_q <= 1'b0;
      result_valid_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      speed_q        <= speed_d;
      stop_q         <= stop_d;
      tick_cnt_q     <= tick_cnt_d;
      timer_q        <= timer_d;
      hit_q          <= hit_d;
      score_q        <= score_d;
      rounds_q       <= rounds_d;
      round_active_q <= round_active_d;
      result_valid_q <= result_valid_d;
      game_over_q    <= game_over_d;
    end
  end

  assign speed_o        = speed_q;
  assign stop_o         = stop_q;
  assign round_active_o = round_active_q;
  assign result_valid_o = result_valid_q;
  assign hit_o          = hit_q;
  assign score_o        = score_q;
  assign rounds_o       = rounds_q;
  assign game_over_o    = game_over_q;

endmodule

// File: tb/tb_spin_round_ctrl.sv
// Bench for spin_round_ctrl with shortened timing parameters. Stimulus queues
// the expected output snapshot and the cycle it should appear on; a monitor
// compares every change of the DUT outputs against the queue head.
module tb_spin_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, btn, wt, wr;
  logic [2:0] pos;
  logic [5:0] guess;
  logic [3:0] speed, score, rounds;
  logic       stop, ra, rv, hit, go;

  always #5 clk = ~clk;

  spin_round_ctrl #(
    .START_SPEED   (4'd4),
    .MIN_SPEED     (4'd2),
    .COAST_TICKS   (2),
    .SPIN_TIMEOUT  (8),
    .RESULT_CYCLES (24'd10),
    .MAX_ROUNDS    (4'd2),
    .SCORE_W       (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .btn_i           (btn),
    .wheel_tick_i    (wt),
    .wheel_running_i (wr),
    .pos_i           (pos),
    .guess_i         (guess),
    .speed_o         (speed),
    .stop_o          (stop),
    .round_active_o  (ra),
    .result_valid_o  (rv),
    .hit_o           (hit),
    .score_o         (score),
    .rounds_o        (rounds),
    .game_over_o     (go)
  );

  typedef struct packed {
    logic [3:0] speed;
    logic       stop;
    logic       ra;
    logic       rv;
    logic       hit;
    logic [3:0] score;
    logic [3:0] rounds;
    logic       go;
  } obs_t;

  typedef struct {
    obs_t v;
    int   c;
  } exp_t;

  exp_t q[$];
  obs_t m;
  obs_t act;
  obs_t prev;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   events  = 0;
  bit   mon_en  = 1'b0;
  bit   started = 1'b0;

  assign act = {speed, stop, ra, rv, hit, score, rounds, go};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input obs_t o);
    return $sformatf("spd=%0d stop=%b act=%b rv=%b hit=%b score=%0d rounds=%0d over=%b",
                     o.speed, o.stop, o.ra, o.rv, o.hit, o.score, o.rounds, o.go);
  endfunction

  // Monitor: every output change pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (!started) begin
        started = 1'b1;
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL reset_state: got %s, required %s", fmt(act), fmt(e.v));
        end
        prev = act;
      end else if (act !== prev) begin
        events++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change at cycle %0d: got %s, required no change", cyc, fmt(act));
        end else begin
          e = q.pop_front();
          if (act !== e.v) begin
            errors++;
            $display("FAIL event%0d_value: got %s, required %s", events, fmt(act), fmt(e.v));
          end
          checks++;
          if (cyc != e.c) begin
            errors++;
            $display("FAIL event%0d_cycle: got cycle %0d, required cycle %0d", events, cyc, e.c);
          end
        end
        prev = act;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int c);
    exp_t e;
    e.v = m;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic tick_once();
    wt = 1'b1;
    step();
    wt = 1'b0;
  endtask

  // Pulse reaches the FSM four edges after btn rises.
  task automatic press();
    btn = 1'b1;
    repeat (4) step();
    btn = 1'b0;
    repeat (4) step();
  endtask

  // From COAST at speed 4: 4->3->2 every two ticks, then stop after two more.
  task automatic coast_to_stop();
    for (int s = 0; s < 3; s++) begin
      tick_once();
      step();
      tick_once();
      if (s < 2) m.speed = m.speed - 4'd1;
      else       m.stop  = 1'b1;
      expect_at(cyc);
      if (s < 2) step();
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; btn = 1'b0; wt = 1'b0; wr = 1'b1; pos = 3'd0; guess = 6'd0;
    m = '0;
    m.stop = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    expect_at(-1);
    mon_en = 1'b1;
    step();

    // Round 1: held button -> one spin; SPIN ticks; second press -> coast
    m.speed = 4'd4; m.stop = 1'b0; m.ra = 1'b1;
    expect_at(cyc + 4);
    btn = 1'b1;
    repeat (20) step();
    btn = 1'b0;
    repeat (4) step();
    repeat (3) begin tick_once(); step(); end
    press();
    guess = 6'b000001; pos = 3'd3;
    coast_to_stop();
    repeat (3) step();
    guess = 6'b001000; pos = 3'd3;
    t0 = cyc;
    wr = 1'b0;
    m.speed = 4'd0; m.ra = 1'b0; m.rv = 1'b1; m.hit = 1'b1; m.score = 4'd1; m.rounds = 4'd1;
    expect_at(t0 + 1);
    m.rv = 1'b0;
    expect_at(t0 + 11);
    step();
    guess = 6'b000000;
    press();
    repeat (6) step();

    // Round 2: timeout into coast, immediate settle, miss, game over
    wr = 1'b1;
    m.speed = 4'd4; m.stop = 1'b0; m.ra = 1'b1;
    expect_at(cyc + 4);
    press();
    wr = 1'b0; guess = 6'b001001; pos = 3'd3;
    repeat (8) begin tick_once(); step(); end
    coast_to_stop();
    m.speed = 4'd0; m.ra = 1'b0; m.rv = 1'b1; m.hit = 1'b0; m.score = 4'd1; m.rounds = 4'd2;
    expect_at(cyc + 1);
    m.rv = 1'b0; m.go = 1'b1;
    expect_at(cyc + 11);
    repeat (15) step();
    m.go = 1'b0; m.score = 4'd0; m.rounds = 4'd0;
    expect_at(cyc + 4);
    press();
    repeat (5) step();

    // Round 3: press coincides with a tick in SPIN; illegal position
    wr = 1'b1;
    m.speed = 4'd4; m.stop = 1'b0; m.ra = 1'b1;
    expect_at(cyc + 4);
    press();
    repeat (5) begin tick_once(); step(); end
    btn = 1'b1;
    repeat (3) step();
    wt = 1'b1;
    step();
    wt = 1'b0;
    repeat (3) step();
    btn = 1'b0;
    repeat (4) step();
    coast_to_stop();
    pos = 3'd7; guess = 6'b100000;
    repeat (2) step();
    t0 = cyc;
    wr = 1'b0;
    m.speed = 4'd0; m.ra = 1'b0; m.rv = 1'b1; m.hit = 1'b0; m.score = 4'd0; m.rounds = 4'd1;
    expect_at(t0 + 1);
    m.rv = 1'b0;
    expect_at(t0 + 11);
    repeat (15) step();

    // Round 4: reset while coasting at speed 3
    wr = 1'b1;
    m.speed = 4'd4; m.stop = 1'b0; m.ra = 1'b1;
    expect_at(cyc + 4);
    press();
    press();
    tick_once();
    step();
    tick_once();
    m.speed = 4'd3;
    expect_at(cyc);
    step();
    step();
    rst = 1'b1;
    m = '0;
    m.stop = 1'b1;
    expect_at(cyc + 1);
    step();
    rst = 1'b0;
    repeat (3) begin tick_once(); step(); end
    repeat (3) step();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d unmatched expectations, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
